// File: rtl/l_frag_pkg.sv
// l_frag_pkg: shared mode-bit offsets and sizing helpers for the LUT fragment
package l_frag_pkg;
  localparam int MODE_REG_OFS = 0;
  localparam int MODE_FRAC_OFS = 1;
  function automatic int cfg_bits(input int k);
    return 2 ** k + 2;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/l_frag_cfg_if.sv
// l_frag_cfg_if: LUT select, config chain and output bundle of one fragment
interface l_frag_cfg_if #(parameter int K = 4);
  logic [K-1:0] I;
  logic CfgShiftEn;
  logic CfgShiftIn;
  logic CfgClear;
  logic QEN;
  logic CfgShiftOut;
  logic CfgValid;
  logic LUTOutput;
  logic CarryOut;
  logic QZ;
  logic Z;
  modport master(output I, CfgShiftEn, CfgShiftIn, CfgClear, QEN,
                 input CfgShiftOut, CfgValid, LUTOutput, CarryOut, QZ, Z);
  modport slave(input I, CfgShiftEn, CfgShiftIn, CfgClear, QEN,
                output CfgShiftOut, CfgValid, LUTOutput, CarryOut, QZ, Z);
endinterface

// File: rtl/l_frag_cfg_mux.sv
// l_frag_mux: K-level 2:1 mux tree over a truth table, plus the upper-half subtree node
module l_frag_mux #(parameter int K = 4) (
  input  logic [2**K-1:0] tbl,
  input  logic [K-1:0]    sel,
  output logic            root,
  output logic            upper
);
  logic [2**K-1:0] v;
  // Each level folds pairs in place; level K-2 leaves the two half-tree nodes in v[1:0].
  always_comb begin
    v = tbl;
    upper = 1'b0;
    for (int s = 0; s < K; s++) begin
      for (int j = 0; j < 2 ** (K - s - 1); j++) v[j] = sel[s] ? v[2*j+1] : v[2*j];
      if (s == K - 2) upper = v[1];
    end
    root = v[0];
  end
endmodule

// File: rtl/l_frag_cfg.sv
// l_frag_cfg: K-input LUT fragment with serial shadow config, commit counter, fracture and output register
module l_frag_cfg import l_frag_pkg::*; #(
  parameter int K = 4,
  parameter logic [cfg_bits(K)-1:0] INIT = '0,
  parameter bit INIT_VALID = 1'b0
) (
  input logic QCK,
  input logic QRT,
  l_frag_cfg_if.slave bus
);
  localparam int CFG_BITS = cfg_bits(K);
  localparam int CW = clog2(CFG_BITS + 1);
  logic [CFG_BITS-1:0] shadow, active, shadow_nxt;
  logic [CW-1:0] count;
  logic valid, qz, commit, frac, root, upper, lut;
  assign shadow_nxt = {bus.CfgShiftIn, shadow[CFG_BITS-1:1]};
  assign commit = bus.CfgShiftEn && !bus.CfgClear && count == CW'(CFG_BITS - 1);
  assign frac = active[2**K+MODE_FRAC_OFS];
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      shadow <= '0;
      count <= '0;
      active <= INIT;
      valid <= INIT_VALID;
      qz <= 1'b0;
    end else begin
      if (bus.CfgClear) begin
        shadow <= '0;
        count <= '0;
        valid <= 1'b0;
      end else if (bus.CfgShiftEn) begin
        shadow <= shadow_nxt;
        count <= commit ? '0 : count + CW'(1);
        if (commit) begin
          active <= shadow_nxt;
          valid <= 1'b1;
        end
      end
      if (bus.QEN && valid) qz <= lut;
    end
  end
  // Fracture mode masks the top select so the root reads the lower half-tree.
  l_frag_mux #(.K(K)) u_mux (
    .tbl(active[2**K-1:0]),
    .sel({bus.I[K-1] & ~frac, bus.I[K-2:0]}),
    .root(root),
    .upper(upper)
  );
  assign lut = valid & root;
  assign bus.LUTOutput = lut;
  assign bus.CarryOut = valid & upper;
  assign bus.CfgValid = valid;
  assign bus.CfgShiftOut = shadow[0];
  assign bus.QZ = qz;
  assign bus.Z = active[2**K+MODE_REG_OFS] ? qz : lut;
endmodule

// File: tb/tb_l_frag_cfg.sv
// tb_l_frag_cfg: directed checks of config load, modes, clear, chaining and reset
module tb_l_frag_cfg;
  logic QCK = 1'b0;
  logic QRT;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [17:0] C_AND = {2'b00, 16'h8000};
  localparam logic [17:0] C_XOR = {2'b01, 16'h6996};
  localparam logic [17:0] C_HFR = {2'b10, 16'hFF00};
  localparam logic [17:0] C_HI = {2'b00, 16'hFF00};
  localparam logic [17:0] C_LO = {2'b00, 16'h00FF};
  localparam logic [17:0] C_ONE = {2'b00, 16'h0001};
  l_frag_cfg_if #(.K(4)) f0 ();
  l_frag_cfg_if #(.K(4)) f1 ();
  assign f1.CfgShiftIn = f0.CfgShiftOut;
  assign f1.CfgShiftEn = f0.CfgShiftEn;
  assign f1.CfgClear = f0.CfgClear;
  assign f1.I = f0.I;
  assign f1.QEN = f0.QEN;
  l_frag_cfg #(.K(4)) u0 (.QCK(QCK), .QRT(QRT), .bus(f0));
  l_frag_cfg #(.K(4)) u1 (.QCK(QCK), .QRT(QRT), .bus(f1));
  always #5 QCK = ~QCK;

  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    f0.CfgShiftEn = 1'b1;
    f0.CfgShiftIn = b;
    tick();
    f0.CfgShiftEn = 1'b0;
  endtask

  task automatic shift_range(input logic [17:0] c, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) shift_bit(c[i]);
  endtask

  task automatic test_reset();
    QRT = 1'b1;
    f0.I = '0; f0.CfgShiftEn = 1'b0; f0.CfgShiftIn = 1'b0; f0.CfgClear = 1'b0; f0.QEN = 1'b0;
    tick();
    tick();
    QRT = 1'b0;
    #1;
    n_chk++; if (f0.CfgValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", f0.CfgValid); end
    n_chk++; if (f0.LUTOutput !== 1'b0) begin n_fail++; $display("FAIL rst_lut got %b exp 0", f0.LUTOutput); end
    n_chk++; if (f0.QZ !== 1'b0) begin n_fail++; $display("FAIL rst_qz got %b exp 0", f0.QZ); end
    n_chk++; if (f0.CfgShiftOut !== 1'b0) begin n_fail++; $display("FAIL rst_shout got %b exp 0", f0.CfgShiftOut); end
  endtask

  task automatic test_and4();
    shift_range(C_AND, 0, 16);
    n_chk++; if (f0.CfgValid !== 1'b0) begin n_fail++; $display("FAIL and_valid17 got %b exp 0", f0.CfgValid); end
    shift_bit(C_AND[17]);
    n_chk++; if (f0.CfgValid !== 1'b1) begin n_fail++; $display("FAIL and_valid18 got %b exp 1", f0.CfgValid); end
    f0.I = 4'hF; #1;
    n_chk++; if (f0.LUTOutput !== 1'b1) begin n_fail++; $display("FAIL and_iF got %b exp 1", f0.LUTOutput); end
    n_chk++; if (f0.Z !== 1'b1) begin n_fail++; $display("FAIL and_zF got %b exp 1", f0.Z); end
    f0.I = 4'h7; #1;
    n_chk++; if (f0.LUTOutput !== 1'b0) begin n_fail++; $display("FAIL and_i7 got %b exp 0", f0.LUTOutput); end
  endtask

  task automatic test_xor_reg();
    shift_range(C_XOR, 0, 17);
    f0.I = 4'h0; f0.QEN = 1'b1;
    tick();
    n_chk++; if (f0.QZ !== 1'b0) begin n_fail++; $display("FAIL xor_qz0 got %b exp 0", f0.QZ); end
    f0.I = 4'h1; #1;
    n_chk++; if (f0.LUTOutput !== 1'b1) begin n_fail++; $display("FAIL xor_lut1 got %b exp 1", f0.LUTOutput); end
    n_chk++; if (f0.Z !== 1'b0) begin n_fail++; $display("FAIL xor_zpre got %b exp 0", f0.Z); end
    tick();
    n_chk++; if (f0.QZ !== 1'b1) begin n_fail++; $display("FAIL xor_qz1 got %b exp 1", f0.QZ); end
    n_chk++; if (f0.Z !== 1'b1) begin n_fail++; $display("FAIL xor_z1 got %b exp 1", f0.Z); end
    f0.QEN = 1'b0; f0.I = 4'h0;
    tick();
    n_chk++; if (f0.QZ !== 1'b1) begin n_fail++; $display("FAIL xor_hold got %b exp 1", f0.QZ); end
    n_chk++; if (f0.LUTOutput !== 1'b0) begin n_fail++; $display("FAIL xor_lut0 got %b exp 0", f0.LUTOutput); end
  endtask

  task automatic test_frac();
    shift_range(C_HFR, 0, 17);
    f0.I = 4'h8; #1;
    n_chk++; if (f0.LUTOutput !== 1'b0) begin n_fail++; $display("FAIL frac_lut got %b exp 0", f0.LUTOutput); end
    n_chk++; if (f0.CarryOut !== 1'b1) begin n_fail++; $display("FAIL frac_carry got %b exp 1", f0.CarryOut); end
    shift_range(C_HI, 0, 17);
    n_chk++; if (f0.LUTOutput !== 1'b1) begin n_fail++; $display("FAIL nofrac_lut got %b exp 1", f0.LUTOutput); end
  endtask

  task automatic test_clear();
    shift_range(C_LO, 0, 9);
    f0.CfgClear = 1'b1; f0.CfgShiftEn = 1'b1; f0.CfgShiftIn = 1'b1;
    tick();
    f0.CfgClear = 1'b0; f0.CfgShiftEn = 1'b0;
    n_chk++; if (f0.CfgValid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %b exp 0", f0.CfgValid); end
    n_chk++; if (f0.LUTOutput !== 1'b0) begin n_fail++; $display("FAIL clr_lut got %b exp 0", f0.LUTOutput); end
    n_chk++; if (f0.CarryOut !== 1'b0) begin n_fail++; $display("FAIL clr_carry got %b exp 0", f0.CarryOut); end
    shift_range(C_LO, 0, 16);
    n_chk++; if (f0.CfgValid !== 1'b0) begin n_fail++; $display("FAIL clr_valid17 got %b exp 0", f0.CfgValid); end
    shift_bit(C_LO[17]);
    n_chk++; if (f0.CfgValid !== 1'b1) begin n_fail++; $display("FAIL clr_valid18 got %b exp 1", f0.CfgValid); end
    n_chk++; if (f0.LUTOutput !== 1'b0) begin n_fail++; $display("FAIL clr_lut8 got %b exp 0", f0.LUTOutput); end
    f0.I = 4'h0; #1;
    n_chk++; if (f0.LUTOutput !== 1'b1) begin n_fail++; $display("FAIL clr_lut0 got %b exp 1", f0.LUTOutput); end
  endtask

  task automatic test_chain();
    f0.CfgClear = 1'b1;
    tick();
    f0.CfgClear = 1'b0;
    shift_range(C_AND, 0, 17);
    shift_range(C_ONE, 0, 17);
    f0.I = 4'hF; #1;
    n_chk++; if (f1.LUTOutput !== 1'b1) begin n_fail++; $display("FAIL chain_far_iF got %b exp 1", f1.LUTOutput); end
    n_chk++; if (f0.LUTOutput !== 1'b0) begin n_fail++; $display("FAIL chain_near_iF got %b exp 0", f0.LUTOutput); end
    f0.I = 4'h0; #1;
    n_chk++; if (f1.LUTOutput !== 1'b0) begin n_fail++; $display("FAIL chain_far_i0 got %b exp 0", f1.LUTOutput); end
    n_chk++; if (f0.LUTOutput !== 1'b1) begin n_fail++; $display("FAIL chain_near_i0 got %b exp 1", f0.LUTOutput); end
  endtask

  task automatic test_reset_midload();
    f0.I = 4'h0; f0.QEN = 1'b1;
    tick();
    f0.QEN = 1'b0;
    n_chk++; if (f0.QZ !== 1'b1) begin n_fail++; $display("FAIL mid_qzpre got %b exp 1", f0.QZ); end
    shift_range(C_LO, 0, 8);
    #2 QRT = 1'b1;
    #1;
    n_chk++; if (f0.QZ !== 1'b0) begin n_fail++; $display("FAIL mid_qzrst got %b exp 0", f0.QZ); end
    n_chk++; if (f0.CfgValid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", f0.CfgValid); end
    f0.QEN = 1'b1;
    tick();
    n_chk++; if (f0.QZ !== 1'b0) begin n_fail++; $display("FAIL mid_qzhold got %b exp 0", f0.QZ); end
    QRT = 1'b0; f0.QEN = 1'b0;
    shift_range(C_AND, 0, 16);
    n_chk++; if (f0.CfgValid !== 1'b0) begin n_fail++; $display("FAIL mid_valid17 got %b exp 0", f0.CfgValid); end
    shift_bit(C_AND[17]);
    n_chk++; if (f0.CfgValid !== 1'b1) begin n_fail++; $display("FAIL mid_valid18 got %b exp 1", f0.CfgValid); end
    f0.I = 4'hF; #1;
    n_chk++; if (f0.LUTOutput !== 1'b1) begin n_fail++; $display("FAIL mid_lut got %b exp 1", f0.LUTOutput); end
  endtask

  initial begin
    test_reset();
    test_and4();
    test_xor_reg();
    test_frac();
    test_clear();
    test_chain();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
